// File: rtl/wb_lsu_master_pkg.sv
// Shared definitions for the Wishbone LSU master: funct3 codes, FSM states and
// the sizing helper for the optional WB_TIMEOUT_EN bus-cycle watchdog.
package wb_lsu_master_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Watchdog counter width: enough to hold the limit, clamped to 8..32 bits.
  function automatic int unsigned timeout_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    if (w < 8)  w = 8;
    if (w > 32) w = 32;
    return w;
  endfunction

endpackage

// File: rtl/wb_lsu_master_if.sv
// Request/response handshake plus the Wishbone B4 classic data-port signals
// of the LSU back end, bundled for the master and its environment.
interface wb_lsu_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_misalign;

  logic [31:0] dwb_adr_o;
  logic [31:0] dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o;
  logic        dwb_cyc_o;
  logic        dwb_stb_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic        dwb_err_i;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_misalign,
    output dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
    input  dwb_dat_i, dwb_ack_i, dwb_err_i
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_misalign,
    input  dwb_adr_o, dwb_dat_o, dwb_sel_o, dwb_we_o, dwb_cyc_o, dwb_stb_o,
    output dwb_dat_i, dwb_ack_i, dwb_err_i
  );

endinterface

// File: rtl/wb_lsu_master_lsu_align.sv
// Combinational byte-lane logic: misalign check and store steering for the
// incoming request, lane extraction and sign/zero extension for load data.
module lsu_align
  import wb_lsu_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic        misalign,
  output logic [3:0]  sel,
  output logic [31:0] dat_steer,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Stores share the size encoding of LB/LH/LW; reserved codes report misaligned.
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    misalign  = 1'b0;
    sel       = 4'b0000;
    dat_steer = 32'h0;
    unique case (funct3)
      FUNCT3_LB, FUNCT3_LBU: begin
        sel       = 4'b0001 << offset;
        dat_steer = {4{wdata[7:0]}};
      end
      FUNCT3_LH, FUNCT3_LHU: begin
        misalign  = offset[0];
        sel       = 4'b0011 << offset;
        dat_steer = {2{wdata[15:0]}};
      end
      FUNCT3_LW: begin
        misalign  = (offset != 2'b00);
        sel       = 4'b1111;
        dat_steer = wdata;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_byte = rdata[7:0];
    unique case (ld_offset)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    ld_data = 32'h0;
    unique case (ld_funct3)
      FUNCT3_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      FUNCT3_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      FUNCT3_LW:  ld_data = rdata;
      FUNCT3_LBU: ld_data = {24'h0, ld_byte};
      FUNCT3_LHU: ld_data = {16'h0, ld_half};
      default:    ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic initiator for the LSU: one request -> one dwb cycle.
// Define WB_TIMEOUT_EN to abort a cycle after TIMEOUT_CYCLES without ack/err.
module wb_lsu_master
  import wb_lsu_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
(
  input logic             clk,
  input logic             rst_n,
  wb_lsu_master_if.master bus
);

  lsu_state_e  state_q, state_d;
  logic        accept, bus_end, bus_fail, timeout;
  logic        misalign;
  logic [3:0]  sel;
  logic [31:0] dat_steer, ld_data;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [3:0]  sel_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        we_q, err_q, misalign_q;

  lsu_align u_align (
    .funct3    (bus.req_funct3),
    .offset    (bus.req_addr[1:0]),
    .wdata     (bus.req_wdata),
    .misalign  (misalign),
    .sel       (sel),
    .dat_steer (dat_steer),
    .ld_funct3 (funct3_q),
    .ld_offset (offset_q),
    .rdata     (bus.dwb_dat_i),
    .ld_data   (ld_data)
  );

  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign bus_fail = bus.dwb_err_i || timeout;
  assign bus_end  = (state_q == ST_BUS) && (bus.dwb_ack_i || bus_fail);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.req_valid) state_d = misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_end)       state_d = ST_RESP;
      ST_RESP:                    state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Request fields freeze at accept; response fields live for the RESP cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q      <= 32'h0;
      dat_q      <= 32'h0;
      sel_q      <= 4'b0000;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        adr_q      <= {bus.req_addr[31:2], 2'b00};
        dat_q      <= dat_steer;
        sel_q      <= sel;
        we_q       <= bus.req_we;
        funct3_q   <= bus.req_funct3;
        offset_q   <= bus.req_addr[1:0];
        misalign_q <= misalign;
      end
      if (bus_end) begin
        err_q   <= bus_fail;
        rdata_q <= (we_q || bus_fail) ? 32'h0 : ld_data;
      end else if (state_q == ST_RESP) begin
        err_q      <= 1'b0;
        misalign_q <= 1'b0;
        rdata_q    <= 32'h0;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TMO_W = timeout_width(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_q <= '0;
    else if (accept)            tmo_q <= '0;
    else if (state_q == ST_BUS) tmo_q <= tmo_q + TMO_W'(1);
  end

  // Fires in the last of TIMEOUT_CYCLES strobe cycles, so cyc drops right after it.
  assign timeout = (state_q == ST_BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.rsp_valid    = (state_q == ST_RESP);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.rsp_misalign = misalign_q;
  assign bus.dwb_adr_o    = adr_q;
  assign bus.dwb_dat_o    = dat_q;
  assign bus.dwb_sel_o    = sel_q;
  assign bus.dwb_cyc_o    = (state_q == ST_BUS);
  assign bus.dwb_stb_o    = (state_q == ST_BUS);
  assign bus.dwb_we_o     = we_q && (state_q == ST_BUS);

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench for wb_lsu_master against a registered 1-wait memory responder;
// the timeout section runs only when WB_TIMEOUT_EN is defined.
module tb_wb_lsu_master;
  import wb_lsu_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  wb_lsu_master_if bus();

  int checks   = 0;
  int failures = 0;

  logic        no_ack, err_mode, bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] mem [16];
  int          ack_count;

  int          r_lat, r_cyc_n, r_acks;
  logic        r_valid, r_err, r_mis, r_ready_busy, r_stable, r_cyc_at_rsp, r_pulse_again, r_we;
  logic [31:0] r_rdata, r_adr, r_dat;
  logic [3:0]  r_sel;

  always #5 clk = ~clk;

  wb_lsu_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  assign bus.dwb_dat_i = bus.dwb_ack_i ? mem[bus.dwb_adr_o[5:2]] : 32'h0;

  // Registered 1-wait responder: acks one cycle after seeing stb with no ack pending.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dwb_ack_i <= 1'b0;
      bus.dwb_err_i <= 1'b0;
      ack_count     <= 0;
      // NOTE: the model memory is cleared on reset so each section starts from known words.
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else begin
      bus.dwb_ack_i <= bus.dwb_cyc_o && bus.dwb_stb_o && !bus.dwb_ack_i && !bus.dwb_err_i && !no_ack;
      bus.dwb_err_i <= bus.dwb_cyc_o && bus.dwb_stb_o && !bus.dwb_ack_i && !bus.dwb_err_i && !no_ack && err_mode;
      if (bus.dwb_cyc_o && (bus.dwb_ack_i || bus.dwb_err_i)) ack_count <= ack_count + 1;
      if (bus.dwb_cyc_o && bus.dwb_ack_i && !bus.dwb_err_i && bus.dwb_we_o)
        for (int i = 0; i < 4; i++)
          if (bus.dwb_sel_o[i]) mem[bus.dwb_adr_o[5:2]][8*i +: 8] <= bus.dwb_dat_o[8*i +: 8];
      if (bd_we) mem[bd_idx] <= bd_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_idx  = idx;
    bd_data = data;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // Issue one request and hold req_valid until the response, sampling #1 after each edge.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int a0;
    a0 = ack_count;
    @(negedge clk);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    r_lat = 0; r_cyc_n = 0; r_ready_busy = 1'b0; r_stable = 1'b1;
    r_adr = 32'h0; r_dat = 32'h0; r_sel = 4'h0; r_we = 1'b0;
    while (!bus.rsp_valid && r_lat < 40) begin
      if (bus.req_ready) r_ready_busy = 1'b1;
      if (bus.dwb_cyc_o) begin
        if (r_cyc_n == 0) begin
          r_adr = bus.dwb_adr_o; r_dat = bus.dwb_dat_o; r_sel = bus.dwb_sel_o; r_we = bus.dwb_we_o;
        end else if (r_adr !== bus.dwb_adr_o || r_dat !== bus.dwb_dat_o ||
                     r_sel !== bus.dwb_sel_o || r_we !== bus.dwb_we_o || !bus.dwb_stb_o) begin
          r_stable = 1'b0;
        end
        r_cyc_n++;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    if (bus.req_ready) r_ready_busy = 1'b1;
    r_valid      = bus.rsp_valid;
    r_rdata      = bus.rsp_rdata;
    r_err        = bus.rsp_err;
    r_mis        = bus.rsp_misalign;
    r_cyc_at_rsp = bus.dwb_cyc_o;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    r_pulse_again = bus.rsp_valid;
    r_acks        = ack_count - a0;
  endtask

  task automatic check_txn(input string tag, input int lat, input int cyc_n,
                           input logic [31:0] rdata, input logic err, input logic mis,
                           input int acks);
    check({tag, ".rsp_valid"},  r_valid, 1'b1);
    check({tag, ".latency"},    r_lat, lat);
    check({tag, ".cyc_cycles"}, r_cyc_n, cyc_n);
    check({tag, ".rdata"},      r_rdata, rdata);
    check({tag, ".err"},        r_err, err);
    check({tag, ".misalign"},   r_mis, mis);
    check({tag, ".transfers"},  r_acks, acks);
    check({tag, ".ready_busy"}, r_ready_busy, 1'b0);
    check({tag, ".stable"},     r_stable, 1'b1);
    check({tag, ".cyc_at_rsp"}, r_cyc_at_rsp, 1'b0);
    check({tag, ".one_pulse"},  r_pulse_again, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; no_ack = 1'b0; err_mode = 1'b0;
    bd_we = 1'b0; bd_idx = 4'h0; bd_data = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    repeat (2) @(posedge clk); #1;
    check("reset.req_ready", bus.req_ready, 1'b1);
    check("reset.rsp_valid", bus.rsp_valid, 1'b0);
    check("reset.rsp_err",   bus.rsp_err, 1'b0);
    check("reset.rsp_mis",   bus.rsp_misalign, 1'b0);
    check("reset.rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset.cyc",       bus.dwb_cyc_o, 1'b0);
    check("reset.stb",       bus.dwb_stb_o, 1'b0);
    check("reset.we",        bus.dwb_we_o, 1'b0);
    check("reset.adr",       bus.dwb_adr_o, 32'h0);
    check("reset.dat",       bus.dwb_dat_o, 32'h0);
    check("reset.sel",       bus.dwb_sel_o, 4'h0);
    @(negedge clk) rst_n = 1'b1;

    // Word store then load back.
    run_req(1'b1, FUNCT3_SW, 32'h0000_1000, 32'hDEAD_BEEF);
    check_txn("sw", 2, 2, 32'h0, 1'b0, 1'b0, 1);
    check("sw.adr", r_adr, 32'h0000_1000);
    check("sw.sel", r_sel, 4'b1111);
    check("sw.dat", r_dat, 32'hDEAD_BEEF);
    check("sw.we",  r_we, 1'b1);
    check("sw.mem", mem[0], 32'hDEAD_BEEF);
    run_req(1'b0, FUNCT3_LW, 32'h0000_1000, 32'h0);
    check_txn("lw", 2, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    check("lw.sel", r_sel, 4'b1111);
    check("lw.we",  r_we, 1'b0);

    // Sub-word loads from 0x80FF7F01 at 0x1004.
    poke(4'd1, 32'h80FF_7F01);
    run_req(1'b0, FUNCT3_LB, 32'h0000_1007, 32'h0);
    check_txn("lb3", 2, 2, 32'hFFFF_FF80, 1'b0, 1'b0, 1);
    check("lb3.sel", r_sel, 4'b1000);
    run_req(1'b0, FUNCT3_LBU, 32'h0000_1007, 32'h0);
    check_txn("lbu3", 2, 2, 32'h0000_0080, 1'b0, 1'b0, 1);
    run_req(1'b0, FUNCT3_LH, 32'h0000_1006, 32'h0);
    check_txn("lh2", 2, 2, 32'hFFFF_80FF, 1'b0, 1'b0, 1);
    check("lh2.sel", r_sel, 4'b1100);
    check("lh2.adr", r_adr, 32'h0000_1004);
    run_req(1'b0, FUNCT3_LHU, 32'h0000_1004, 32'h0);
    check_txn("lhu0", 2, 2, 32'h0000_7F01, 1'b0, 1'b0, 1);

    // Sub-word stores: byte lane 1 and upper halfword.
    poke(4'd0, 32'h1122_3344);
    run_req(1'b1, FUNCT3_SB, 32'h0000_1001, 32'hFFFF_FFA5);
    check_txn("sb1", 2, 2, 32'h0, 1'b0, 1'b0, 1);
    check("sb1.sel", r_sel, 4'b0010);
    check("sb1.dat", r_dat, 32'hA5A5_A5A5);
    check("sb1.mem", mem[0], 32'h1122_A544);
    poke(4'd2, 32'h0000_0000);
    run_req(1'b1, FUNCT3_SH, 32'h0000_100A, 32'h1234_BEEF);
    check_txn("sh2", 2, 2, 32'h0, 1'b0, 1'b0, 1);
    check("sh2.sel", r_sel, 4'b1100);
    check("sh2.dat", r_dat, 32'hBEEF_BEEF);
    check("sh2.mem", mem[2], 32'hBEEF_0000);

    // Misaligned and reserved encodings: response in the cycle right after accept, no bus cycle.
    run_req(1'b0, FUNCT3_LW, 32'h0000_1002, 32'h0);
    check_txn("lw_mis", 0, 0, 32'h0, 1'b0, 1'b1, 0);
    run_req(1'b0, FUNCT3_LH, 32'h0000_1001, 32'h0);
    check_txn("lh_mis", 0, 0, 32'h0, 1'b0, 1'b1, 0);
    run_req(1'b0, 3'b111, 32'h0000_1000, 32'h0);
    check_txn("f3_111", 0, 0, 32'h0, 1'b0, 1'b1, 0);

    // Error terminations: err beats a simultaneous ack; failed store leaves memory alone.
    err_mode = 1'b1;
    run_req(1'b0, FUNCT3_LW, 32'h0000_1000, 32'h0);
    check_txn("lw_err", 2, 2, 32'h0, 1'b1, 1'b0, 1);
    run_req(1'b1, FUNCT3_SW, 32'h0000_100C, 32'h5555_AAAA);
    check_txn("sw_err", 2, 2, 32'h0, 1'b1, 1'b0, 1);
    check("sw_err.mem", mem[3], 32'h0);
    err_mode = 1'b0;

    // Reset asserted mid-cycle while the bus cycle is open.
    no_ack = 1'b1;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_funct3 = FUNCT3_LW; bus.req_addr = 32'h0000_1000;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rst_bus.cyc_open", bus.dwb_cyc_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bus.cyc",       bus.dwb_cyc_o, 1'b0);
    check("rst_bus.stb",       bus.dwb_stb_o, 1'b0);
    check("rst_bus.req_ready", bus.req_ready, 1'b1);
    check("rst_bus.adr",       bus.dwb_adr_o, 32'h0);
    check("rst_bus.sel",       bus.dwb_sel_o, 4'h0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_bus.no_rsp", bus.rsp_valid, 1'b0);
    end
    @(negedge clk) rst_n = 1'b1;
    no_ack = 1'b0;

    poke(4'd5, 32'hCAFE_F00D);
    run_req(1'b0, FUNCT3_LW, 32'h0000_1014, 32'h0);
    check_txn("post_rst_lw", 2, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1);

`ifdef WB_TIMEOUT_EN
    // Silent slave: strobe held for exactly 16 cycles, then error response.
    no_ack = 1'b1;
    run_req(1'b0, FUNCT3_LW, 32'h0000_1010, 32'h0);
    check_txn("timeout", 16, 16, 32'h0, 1'b1, 1'b0, 0);
    no_ack = 1'b0;
    run_req(1'b0, FUNCT3_LW, 32'h0000_1014, 32'h0);
    check_txn("post_tmo_lw", 2, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
